// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 multiplier front end: format constants,
// sequencer state encoding and result flag bit positions.
package fp_pkg;

  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    NORM  = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalize, round-to-nearest-even and pack of a 48-bit
// significand product into a binary32 result with exception flags.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic               [47:0] product,
  input  logic                      sign,
  input  logic signed        [9:0]  exp_sum,
  output logic               [31:0] result,
  output logic               [3:0]  flags
);

  function automatic logic round_up(input logic guard, input logic sticky, input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  logic [FRAC_W-1:0] frac;
  logic              guard;
  logic              sticky;
  logic              inexact;
  logic [FRAC_W:0]   frac_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;

  always_comb begin
    frac    = product[45:23];
    guard   = product[22];
    sticky  = |product[21:0];
    exp_n   = exp_sum;
    if (product[47]) begin
      frac   = product[46:24];
      guard  = product[23];
      sticky = |product[22:0];
      exp_n  = exp_sum + 10'sd1;
    end

    // A carry out of the fraction leaves frac_r[22:0] at zero, so only the exponent moves.
    frac_r  = {1'b0, frac} + {{FRAC_W{1'b0}}, round_up(guard, sticky, frac[0])};
    exp_f   = frac_r[FRAC_W] ? exp_n + 10'sd1 : exp_n;
    inexact = guard | sticky;

    result = {sign, exp_f[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    flags  = '0;
    flags[FLAG_INEXACT] = inexact;

    if (exp_f >= 10'sd255) begin
      result = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= 10'sd0) begin
      result = {sign, {(EXP_W+FRAC_W){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Binary32 multiply front end: unpacks operands, resolves special cases, drives
// the mantissa core over start/done, then rounds, packs and holds the result.
module fp_mul_sequencer
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        core_start,
  output logic [23:0] core_m,
  output logic [23:0] core_q,
  input  logic        core_done,
  input  logic [47:0] core_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  state_t state, state_n;

  logic              sign_p0;
  logic signed [9:0] exp_sum_p0;
  logic [47:0]       product_p1;

  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              sign_in;
  logic signed [9:0] exp_sum_in;
  logic              special;
  logic [31:0]       spec_result;
  logic [3:0]        spec_flags;

  logic [31:0]       rp_result;
  logic [3:0]        rp_flags;

  assign ea = in_a[30:23];
  assign eb = in_b[30:23];
  assign fa = in_a[22:0];
  assign fb = in_b[22:0];

  // Denormals count as zero here, including for the inf x zero check.
  assign a_nan  = (ea == 8'hFF) && (fa != '0);
  assign b_nan  = (eb == 8'hFF) && (fb != '0);
  assign a_inf  = (ea == 8'hFF) && (fa == '0);
  assign b_inf  = (eb == 8'hFF) && (fb == '0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);

  assign sign_in    = in_a[31] ^ in_b[31];
  assign exp_sum_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

  always_comb begin
    special     = 1'b1;
    spec_result = '0;
    spec_flags  = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_result = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_result = {sign_in, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      spec_result = {sign_in, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  fp_round_pack u_round_pack (
    .product (product_p1),
    .sign    (sign_p0),
    .exp_sum (exp_sum_p0),
    .result  (rp_result),
    .flags   (rp_flags)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = special ? OUT : ISSUE;
      end
      ISSUE: begin
        core_start = 1'b1;
        state_n    = WAIT;
      end
      WAIT:  if (core_done) state_n = NORM;
      NORM:  state_n = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 0: operand accept; stage 1: product capture; stage 2: packed result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      core_m     <= '0;
      core_q     <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (special) begin
            out_result <= spec_result;
            out_flags  <= spec_flags;
          end else begin
            core_m <= {1'b1, fa};
            core_q <= {1'b1, fb};
          end
        end
        NORM: begin
          out_result <= rp_result;
          out_flags  <= rp_flags;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_p0    <= sign_in;
      exp_sum_p0 <= exp_sum_in;
    end
    if (state == WAIT && core_done) product_p1 <= core_product;
  end

endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed bench for fp_mul_sequencer; the bench plays the mantissa core.
module tb_fp_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        core_start;
  logic [23:0] core_m;
  logic [23:0] core_q;
  logic        core_done = 1'b0;
  logic [47:0] core_product = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp_mul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .core_start   (core_start),
    .core_m       (core_m),
    .core_q       (core_q),
    .core_done    (core_done),
    .core_product (core_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic run_normal(input logic [31:0] a, input logic [31:0] b, input int lat,
                            input logic [31:0] er, input logic [3:0] ef, input int hold);
    logic [23:0] m, q;
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("core_start_pulse", core_start, 1);
    m = core_m;
    q = core_q;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      check("core_start_once", core_start, 0);
      check("out_valid_wait", out_valid, 0);
    end
    check("core_m_stable", core_m, m);
    check("core_q_stable", core_q, q);
    core_done = 1'b1;
    core_product = {24'd0, m} * {24'd0, q};
    @(posedge clk); #1;
    core_done = 1'b0;
    check("out_valid_norm", out_valid, 0);
    @(posedge clk); #1;
    check("out_valid", out_valid, 1);
    check("out_result", out_result, er);
    check("out_flags", out_flags, ef);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, er);
      check("hold_flags", out_flags, ef);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  task automatic run_special(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("spec_out_valid_c1", out_valid, 1);
    check("spec_no_core_start", core_start, 0);
    check("spec_result", out_result, er);
    check("spec_flags", out_flags, ef);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("spec_in_ready_back", in_ready, 1);
    check("spec_no_core_start2", core_start, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_core_start", core_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_core_m", core_m, 0);
    check("rst_core_q", core_q, 0);
    reset = 1'b1;

    // 1.5 x 2.0
    run_normal(32'h3FC0_0000, 32'h4000_0000, 3, 32'h4040_0000, 4'b0000, 0);
    // exact, p[47]=0
    run_normal(32'h3F80_0000, 32'h3F80_0001, 1, 32'h3F80_0001, 4'b0000, 0);
    // zero x inf
    run_special(32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
    // NaN operand
    run_special(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
    // inf x -2
    run_special(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000);
    // -denormal x 3.0 flushes to -0
    run_special(32'h8000_0001, 32'h4040_0000, 32'h8000_0000, 4'b0000);
    // overflow
    run_normal(32'h7F00_0000, 32'h7F00_0000, 2, 32'h7F80_0000, 4'b0101, 0);
    // underflow, negative sign
    run_normal(32'h8080_0000, 32'h0080_0000, 2, 32'h8000_0000, 4'b0011, 0);
    // sticky only, with backpressure
    run_normal(32'h3F80_0001, 32'h3F80_0001, 4, 32'h3F80_0002, 4'b0001, 5);

    // reset during WAIT, then a stale core_done
    @(negedge clk);
    in_a = 32'h3FC0_0000; in_b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstwait_core_start", core_start, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("rstwait_in_ready", in_ready, 1);
    check("rstwait_core_start0", core_start, 0);
    core_done = 1'b1;
    core_product = 48'h6000_0000_0000;
    @(posedge clk); #1;
    core_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_done_out_valid", out_valid, 0);
      check("stale_done_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    run_normal(32'h3FC0_0000, 32'h4000_0000, 2, 32'h4040_0000, 4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
